// File: rtl/heichips25_link_pkg.sv
// heichips25_link_pkg: shared widths, request struct and target ids for the link scheduler
package heichips25_link_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int MAX_OUT = 2;
  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] strb;
    logic                write;
  } link_req_t;
  typedef enum logic {TGT_INST = 1'b0, TGT_DATA = 1'b1} target_e;
endpackage

// File: rtl/heichips25_link_sched_if.sv
// heichips25_link_sched_if: core-side requesters, serial link and response ports of the link scheduler
interface heichips25_link_sched_if #(
  parameter int AddrWidth      = heichips25_link_pkg::ADDR_W,
  parameter int DataWidth      = heichips25_link_pkg::DATA_W,
  parameter int MaxOutstanding = heichips25_link_pkg::MAX_OUT
);
  localparam int CntW = $clog2(MaxOutstanding + 1);
  logic                   inst_valid_i, inst_ready_o;
  logic [AddrWidth-1:0]   inst_addr_i;
  logic                   data_valid_i, data_ready_o, data_write_i;
  logic [AddrWidth-1:0]   data_addr_i;
  logic [DataWidth-1:0]   data_wdata_i;
  logic [DataWidth/8-1:0] data_strb_i;
  logic                   req_valid_o, req_ready_i, req_write_o;
  logic [AddrWidth-1:0]   req_addr_o;
  logic [DataWidth-1:0]   req_wdata_o;
  logic [DataWidth/8-1:0] req_strb_o;
  logic                   rsp_valid_i, rsp_ready_o;
  logic [DataWidth-1:0]   rsp_data_i;
  logic                   inst_rsp_valid_o;
  logic [DataWidth-1:0]   inst_rsp_data_o;
  logic                   data_rsp_valid_o, data_rsp_ready_i;
  logic [DataWidth-1:0]   data_rsp_data_o;
  logic [CntW-1:0]        outstanding_o;
  logic                   spurious_o;
  modport slave (
    input  inst_valid_i, inst_addr_i, data_valid_i, data_addr_i, data_wdata_i, data_strb_i, data_write_i,
           req_ready_i, rsp_valid_i, rsp_data_i, data_rsp_ready_i,
    output inst_ready_o, data_ready_o, req_valid_o, req_addr_o, req_wdata_o, req_strb_o, req_write_o,
           rsp_ready_o, inst_rsp_valid_o, inst_rsp_data_o, data_rsp_valid_o, data_rsp_data_o,
           outstanding_o, spurious_o
  );
  modport master (
    output inst_valid_i, inst_addr_i, data_valid_i, data_addr_i, data_wdata_i, data_strb_i, data_write_i,
           req_ready_i, rsp_valid_i, rsp_data_i, data_rsp_ready_i,
    input  inst_ready_o, data_ready_o, req_valid_o, req_addr_o, req_wdata_o, req_strb_o, req_write_o,
           rsp_ready_o, inst_rsp_valid_o, inst_rsp_data_o, data_rsp_valid_o, data_rsp_data_o,
           outstanding_o, spurious_o
  );
endinterface

// File: rtl/heichips25_link_tracker.sv
// heichips25_link_tracker: in-order FIFO of the requester id of every read in flight
module heichips25_link_tracker import heichips25_link_pkg::*; #(
  parameter int Depth = MAX_OUT,
  localparam int PtrW = Depth > 1 ? $clog2(Depth) : 1,
  localparam int CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push,
  input  target_e         din,
  input  logic            pop,
  output target_e         head,
  output logic [CntW-1:0] count,
  output logic            empty,
  output logic            full
);
  target_e mem [Depth];
  logic [PtrW-1:0] wptr, rptr;
  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return p == PtrW'(Depth - 1) ? '0 : p + 1'b1;
  endfunction
  assign head  = mem[rptr];
  assign empty = count == '0;
  assign full  = count == CntW'(Depth);
  // Storage: ids need no reset, only the pointers and count define validity
  always_ff @(posedge clk_i)
    if (push) mem[wptr] <= din;
  // Pointers wrap at Depth; a simultaneous push and pop leaves the count alone
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= nxt(wptr);
      if (pop) rptr <= nxt(rptr);
      count <= count + CntW'(push) - CntW'(pop);
    end
endmodule

// File: rtl/heichips25_link_sched.sv
// heichips25_link_sched: round-robin fetch/LSU arbitration onto one link slot with in-order response steering
module heichips25_link_sched import heichips25_link_pkg::*; #(
  parameter int AddrWidth      = ADDR_W,
  parameter int DataWidth      = DATA_W,
  parameter int MaxOutstanding = MAX_OUT
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  heichips25_link_sched_if.slave bus
);
  localparam int CntW = $clog2(MaxOutstanding + 1);
  target_e                rr_q, head;
  logic                   empty, full, push, pop, slot_free, head_inst;
  logic                   inst_elig, data_elig, inst_gnt, data_gnt;
  logic [CntW-1:0]        count;
  logic [AddrWidth-1:0]   next_addr;
  logic [DataWidth-1:0]   next_wdata;
  logic [DataWidth/8-1:0] next_strb;
  logic                   next_write;
  assign slot_free  = !bus.req_valid_o || bus.req_ready_i;
  assign inst_elig  = bus.inst_valid_i && slot_free && !full;
  assign data_elig  = bus.data_valid_i && slot_free && (bus.data_write_i || !full);
  assign inst_gnt   = inst_elig && (!data_elig || rr_q == TGT_INST);
  assign data_gnt   = data_elig && (!inst_elig || rr_q == TGT_DATA);
  assign bus.inst_ready_o = inst_gnt;
  assign bus.data_ready_o = data_gnt;
  assign next_addr  = inst_gnt ? bus.inst_addr_i : bus.data_addr_i;
  assign next_wdata = inst_gnt ? '0 : bus.data_wdata_i;
  assign next_strb  = inst_gnt ? '0 : bus.data_strb_i;
  assign next_write = !inst_gnt && bus.data_write_i;
  assign push       = inst_gnt || (data_gnt && !bus.data_write_i);
  assign head_inst  = head == TGT_INST;
  assign bus.rsp_ready_o      = empty || head_inst || bus.data_rsp_ready_i;
  assign bus.inst_rsp_valid_o = bus.rsp_valid_i && !empty && head_inst;
  assign bus.data_rsp_valid_o = bus.rsp_valid_i && !empty && !head_inst;
  assign bus.inst_rsp_data_o  = bus.rsp_data_i;
  assign bus.data_rsp_data_o  = bus.rsp_data_i;
  assign pop               = bus.rsp_valid_i && !empty && bus.rsp_ready_o;
  assign bus.outstanding_o = count;
  heichips25_link_tracker #(.Depth(MaxOutstanding)) u_tracker (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (push),
    .din   (inst_gnt ? TGT_INST : TGT_DATA),
    .pop   (pop),
    .head  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );
  // Request slot: take the winner when free, otherwise drop valid once the serializer accepts
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      bus.req_valid_o <= 1'b0;
      bus.req_addr_o  <= '0;
      bus.req_wdata_o <= '0;
      bus.req_strb_o  <= '0;
      bus.req_write_o <= 1'b0;
    end else if (inst_gnt || data_gnt) begin
      bus.req_valid_o <= 1'b1;
      bus.req_addr_o  <= next_addr;
      bus.req_wdata_o <= next_wdata;
      bus.req_strb_o  <= next_strb;
      bus.req_write_o <= next_write;
    end else if (bus.req_ready_i) bus.req_valid_o <= 1'b0;
  // Round-robin pointer only moves when both requesters contended
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) rr_q <= TGT_INST;
    else if (inst_elig && data_elig) rr_q <= rr_q == TGT_INST ? TGT_DATA : TGT_INST;
  // Sticky flag for a response word arriving with nothing in flight
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) bus.spurious_o <= 1'b0;
    else if (bus.rsp_valid_i && empty) bus.spurious_o <= 1'b1;
endmodule

// File: tb/tb_heichips25_link_sched.sv
// tb_heichips25_link_sched: directed plus random stimulus against a queue-based model of the link scheduler
module tb_heichips25_link_sched;
  import heichips25_link_pkg::*;
  localparam int AW = ADDR_W, DW = DATA_W, MO = MAX_OUT;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int errors = 0, checks = 0;
  link_req_t m_req;
  logic m_valid, m_rr, m_spur;
  int q[$];
  logic [AW-1:0] saved_addr;
  always #5 clk_i = ~clk_i;
  heichips25_link_sched_if #(.AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)) bus ();
  heichips25_link_sched #(.AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    m_req = '0;
    m_valid = 1'b0;
    m_rr = 1'b0;
    m_spur = 1'b0;
    q.delete();
  endtask
  task automatic idle();
    bus.inst_valid_i = 0; bus.inst_addr_i = '0;
    bus.data_valid_i = 0; bus.data_addr_i = '0; bus.data_wdata_i = '0;
    bus.data_strb_i = '0; bus.data_write_i = 0;
    bus.req_ready_i = 1; bus.rsp_valid_i = 0; bus.rsp_data_i = '0; bus.data_rsp_ready_i = 1;
  endtask
  task automatic randomize_inputs();
    bus.inst_valid_i = 1'($urandom_range(0, 1)); bus.inst_addr_i = AW'($urandom);
    bus.data_valid_i = 1'($urandom_range(0, 1)); bus.data_addr_i = AW'($urandom);
    bus.data_wdata_i = DW'($urandom); bus.data_strb_i = 4'($urandom);
    bus.data_write_i = 1'($urandom_range(0, 1));
    bus.req_ready_i = $urandom_range(0, 3) != 0;
    bus.rsp_valid_i = 1'($urandom_range(0, 1)); bus.rsp_data_i = DW'($urandom);
    bus.data_rsp_ready_i = $urandom_range(0, 3) != 0;
  endtask
  task automatic reset_check(input string tag);
    chk({tag, "_req_valid"}, bus.req_valid_o, 0);
    chk({tag, "_req_addr"}, bus.req_addr_o, 0);
    chk({tag, "_req_wdata"}, bus.req_wdata_o, 0);
    chk({tag, "_req_strb"}, bus.req_strb_o, 0);
    chk({tag, "_req_write"}, bus.req_write_o, 0);
    chk({tag, "_outstanding"}, bus.outstanding_o, 0);
    chk({tag, "_spurious"}, bus.spurious_o, 0);
    chk({tag, "_inst_rsp_valid"}, bus.inst_rsp_valid_o, 0);
    chk({tag, "_data_rsp_valid"}, bus.data_rsp_valid_o, 0);
    chk({tag, "_rsp_ready"}, bus.rsp_ready_o, 1);
  endtask
  task automatic step();
    logic can, room, ie, de, gi, gd, rv, emp;
    int hd;
    #1;
    can = !m_valid || bus.req_ready_i;
    room = q.size() < MO;
    ie = bus.inst_valid_i && can && room;
    de = bus.data_valid_i && can && (bus.data_write_i || room);
    gi = ie && (!de || !m_rr);
    gd = de && (!ie || m_rr);
    emp = q.size() == 0;
    hd = emp ? 0 : q[0];
    rv = bus.rsp_valid_i;
    chk("inst_ready", bus.inst_ready_o, gi);
    chk("data_ready", bus.data_ready_o, gd);
    chk("req_valid", bus.req_valid_o, m_valid);
    if (m_valid) begin
      chk("req_addr", bus.req_addr_o, m_req.addr);
      chk("req_wdata", bus.req_wdata_o, m_req.data);
      chk("req_strb", bus.req_strb_o, m_req.strb);
      chk("req_write", bus.req_write_o, m_req.write);
    end
    chk("outstanding", bus.outstanding_o, q.size());
    chk("spurious", bus.spurious_o, m_spur);
    chk("rsp_ready", bus.rsp_ready_o, emp || hd == 0 || bus.data_rsp_ready_i);
    chk("inst_rsp_valid", bus.inst_rsp_valid_o, rv && !emp && hd == 0);
    chk("data_rsp_valid", bus.data_rsp_valid_o, rv && !emp && hd == 1);
    if (rv && !emp && hd == 0) chk("inst_rsp_data", bus.inst_rsp_data_o, bus.rsp_data_i);
    if (rv && !emp && hd == 1) chk("data_rsp_data", bus.data_rsp_data_o, bus.rsp_data_i);
    @(posedge clk_i);
    if (rv && emp) m_spur = 1'b1;
    if (rv && !emp && (hd == 0 || bus.data_rsp_ready_i)) void'(q.pop_front());
    if (gi) q.push_back(0);
    if (gd && !bus.data_write_i) q.push_back(1);
    if (gi) begin
      m_valid = 1'b1;
      m_req = '{addr: bus.inst_addr_i, data: '0, strb: '0, write: 1'b0};
    end else if (gd) begin
      m_valid = 1'b1;
      m_req = '{addr: bus.data_addr_i, data: bus.data_wdata_i, strb: bus.data_strb_i, write: bus.data_write_i};
    end else if (bus.req_ready_i) m_valid = 1'b0;
    if (ie && de) m_rr = !m_rr;
    @(negedge clk_i);
  endtask
  task automatic drain();
    bus.inst_valid_i = 0; bus.data_valid_i = 0; bus.data_rsp_ready_i = 1; bus.req_ready_i = 1;
    for (int n = 0; n < 8 && q.size() != 0; n++) begin
      bus.rsp_valid_i = 1; bus.rsp_data_i = DW'($urandom);
      step();
    end
    bus.rsp_valid_i = 0;
    #1 chk("drain_outstanding", bus.outstanding_o, 0);
  endtask
  initial begin
    idle();
    m_reset();
    repeat (2) @(negedge clk_i);
    #1 reset_check("por");
    rst_ni = 1'b1;
    @(negedge clk_i);
    // single fetch and its response
    bus.inst_valid_i = 1; bus.inst_addr_i = 8'h10;
    step();
    bus.inst_valid_i = 0;
    #1 chk("t1_req_valid", bus.req_valid_o, 1);
    chk("t1_req_addr", bus.req_addr_o, 8'h10);
    chk("t1_req_strb", bus.req_strb_o, 0);
    chk("t1_outstanding", bus.outstanding_o, 1);
    step();
    bus.rsp_valid_i = 1; bus.rsp_data_i = 32'hDEADBEEF;
    #1 chk("t1_inst_rsp_valid", bus.inst_rsp_valid_o, 1);
    chk("t1_inst_rsp_data", bus.inst_rsp_data_o, 32'hDEADBEEF);
    step();
    bus.rsp_valid_i = 0;
    #1 chk("t1_outstanding_after", bus.outstanding_o, 0);
    // fetch and load contend every cycle
    bus.inst_valid_i = 1; bus.data_valid_i = 1; bus.data_write_i = 0;
    for (int i = 0; i < 8; i++) begin
      bus.inst_addr_i = AW'($urandom); bus.data_addr_i = AW'($urandom);
      bus.rsp_valid_i = q.size() != 0; bus.rsp_data_i = DW'($urandom);
      #1 chk("t2_alternate", bus.inst_ready_o, i % 2 == 0);
      step();
    end
    drain();
    // tracker full blocks fetches but not stores
    bus.inst_valid_i = 1;
    step();
    step();
    bus.data_valid_i = 1; bus.data_write_i = 1; bus.data_addr_i = 8'h20;
    bus.data_wdata_i = 32'h12345678; bus.data_strb_i = 4'hF;
    #1 chk("t3_inst_held", bus.inst_ready_o, 0);
    chk("t3_store_granted", bus.data_ready_o, 1);
    step();
    bus.inst_valid_i = 0; bus.data_valid_i = 0;
    #1 chk("t3_req_addr", bus.req_addr_o, 8'h20);
    chk("t3_req_wdata", bus.req_wdata_o, 32'h12345678);
    chk("t3_req_strb", bus.req_strb_o, 4'hF);
    chk("t3_req_write", bus.req_write_o, 1);
    drain();
    // load response stalled by the LSU
    bus.data_valid_i = 1; bus.data_write_i = 0; bus.data_addr_i = 8'h33;
    step();
    bus.data_valid_i = 0;
    step();
    bus.rsp_valid_i = 1; bus.rsp_data_i = 32'hCAFEF00D; bus.data_rsp_ready_i = 0;
    repeat (3) begin
      #1 chk("t4_rsp_ready", bus.rsp_ready_o, 0);
      chk("t4_data_rsp_valid", bus.data_rsp_valid_o, 1);
      step();
    end
    bus.data_rsp_ready_i = 1;
    step();
    bus.rsp_valid_i = 0;
    #1 chk("t4_outstanding", bus.outstanding_o, 0);
    // serializer back-pressure, then push and pop together
    bus.req_ready_i = 0; bus.inst_valid_i = 1; bus.inst_addr_i = 8'h44;
    step();
    saved_addr = bus.req_addr_o;
    bus.data_valid_i = 1; bus.data_write_i = 1; bus.inst_addr_i = 8'h55;
    repeat (4) begin
      #1 chk("t5_inst_ready", bus.inst_ready_o, 0);
      chk("t5_data_ready", bus.data_ready_o, 0);
      chk("t5_req_addr_stable", bus.req_addr_o, saved_addr);
      step();
    end
    bus.data_valid_i = 0; bus.req_ready_i = 1; bus.rsp_valid_i = 1;
    step();
    bus.inst_valid_i = 0; bus.rsp_valid_i = 0;
    #1 chk("t5_outstanding", bus.outstanding_o, 1);
    drain();
    // response with nothing in flight
    bus.rsp_valid_i = 1; bus.rsp_data_i = 32'h0BAD0BAD;
    #1 chk("t6_rsp_ready", bus.rsp_ready_o, 1);
    chk("t6_inst_rsp_valid", bus.inst_rsp_valid_o, 0);
    chk("t6_data_rsp_valid", bus.data_rsp_valid_o, 0);
    step();
    bus.rsp_valid_i = 0;
    #1 chk("t6_spurious", bus.spurious_o, 1);
    step();
    // random traffic, reset mid-burst, more traffic
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      step();
    end
    randomize_inputs();
    #2 rst_ni = 1'b0;
    #1 reset_check("mid");
    m_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 60; i++) begin
      randomize_inputs();
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/heichips25_link_sched.md
Name: heichips25_link_sched

Overview:
Schedules the single narrow off-chip memory link between the Snitch instruction-fetch port and the LSU data port. It round-robin arbitrates the two requesters into one registered request slot, which feeds the 4-bit request serializer. It records the issuing port of every read in an in-order tracker and steers each returning response word back to that port. It sits between the core and the serial request/response converters, replacing ad-hoc target selection.

Parameters:
AddrWidth, 8, word address width on the link
DataWidth, 32, request/response data width
MaxOutstanding, 2, reads in flight at once (tracker depth, ≥1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
inst_valid_i  in  1  fetch request valid
inst_ready_o  out  1  fetch request accepted
inst_addr_i  in  AddrWidth  fetch word address
data_valid_i  in  1  LSU request valid
data_ready_o  out  1  LSU request accepted
data_addr_i  in  AddrWidth  LSU word address
data_wdata_i  in  DataWidth  LSU write data
data_strb_i  in  DataWidth/8  LSU byte strobes
data_write_i  in  1  1 = store, 0 = load
req_valid_o  out  1  link request valid
req_ready_i  in  1  serializer accepts request
req_addr_o  out  AddrWidth  link address
req_wdata_o  out  DataWidth  link write data (0 for fetch)
req_strb_o  out  DataWidth/8  link strobes (0 for fetch)
req_write_o  out  1  link write flag
rsp_valid_i  in  1  deserialized response word valid
rsp_ready_o  out  1  response consumed
rsp_data_i  in  DataWidth  response word
inst_rsp_valid_o  out  1  fetch data valid (no back-pressure)
inst_rsp_data_o  out  DataWidth  fetch data
data_rsp_valid_o  out  1  load data valid
data_rsp_ready_i  in  1  LSU accepts load data
data_rsp_data_o  out  DataWidth  load data
outstanding_o  out  $clog2(MaxOutstanding+1)  reads in flight
spurious_o  out  1  sticky: response arrived with tracker empty

Behaviour:
- Clock and reset are decided: one clock, clk_i; reset rst_ni is asynchronous and active-low.
- Reset: req_valid_o=0, all req_* data outputs=0, rr pointer=inst, tracker empty, outstanding_o=0, spurious_o=0. Reset mid-transaction discards the slot and tracker contents, with no response routed.
- Request slot:
  - Single register holding req_* outputs.
  - Loads when it is empty, or when it is draining in the same cycle (req_valid_o & req_ready_i).
  - Result: one-cycle latency and full throughput.
  - req_* outputs are held stable while req_valid_o=1 and req_ready_i=0.
- Eligibility:
  - A requester is eligible if its valid is high and the slot can load.
  - A read (any fetch, or an LSU load) is also eligible only if count_q < MaxOutstanding.
  - The count used is the registered one; a same-cycle pop does not free a slot.
  - LSU stores ignore the tracker.
- Arbitration:
  - If both requesters are eligible, the one pointed to by the rr pointer wins, and the pointer then moves to the other requester.
  - If only one is eligible, it wins and the pointer is unchanged.
  - The winner's ready is high in the same cycle (ready depends on valid; valid must not depend on ready).
- Tracker push:
  - Happens on the grant of a read, in the grant cycle.
  - Stored ID: 0 = inst, 1 = data.
  - A store pushes nothing and expects no response.
- Response routing, when rsp_valid_i=1:
  - Tracker head = inst: inst_rsp_valid_o=1 and rsp_ready_o=1; pop.
  - Tracker head = data: data_rsp_valid_o=1 and rsp_ready_o=data_rsp_ready_i; pop on handshake.
  - Tracker empty: rsp_ready_o=1, the word is dropped, and spurious_o is set (sticky until reset).
  - rsp_data_i is passed combinationally to both rsp data outputs.
- Simultaneous push and pop: the count is unchanged and the FIFO pointers both advance; ordering is preserved.
- outstanding_o shows the registered count.

Decomposition:
- Package heichips25_link_pkg:
  - typedef link_req_t (addr, data, strb, write);
  - target_e {TGT_INST, TGT_DATA};
  - default widths.
- Sub-module heichips25_link_tracker: parametric 1-bit-wide FIFO with depth MaxOutstanding.
  - Interface: push/pop, head, count, empty/full.
  - Read and write pointers wrap.
  - The arbiter and slot stay in the top.

Test Plan:
1. Fetch only, addr 0x10, req_ready_i=1 → req_valid_o next cycle, addr 0x10, write=0, strb=0. Response 0xDEADBEEF → inst_rsp_valid_o=1, data 0xDEADBEEF, outstanding_o 1→0.
2. Fetch and load both valid every cycle, ready=1 → grants alternate inst, data, inst, data. Responses A, B, C, D route to inst, data, inst, data in order.
3. MaxOutstanding=2, two fetches issued with no response → third fetch held (inst_ready_o=0). A store from the LSU is still granted: addr 0x20, wdata 0x12345678, strb 0xF.
4. LSU load outstanding and data_rsp_ready_i=0 for 3 cycles → rsp_ready_o=0 and data_rsp_valid_o=1 held. Tracker is not popped until ready rises.
5. req_ready_i=0 for 4 cycles with the slot full → req_* stable; both input readies 0. A push and a pop in the same cycle keep outstanding_o at 1.
6. rsp_valid_i with tracker empty → rsp_ready_o=1, no rsp valid asserted, spurious_o=1 until rst_ni asserted mid-burst. After reset all outputs are 0 and the tracker is empty.
